miner_run_monitor: RTL and testbench

Parametrised run controller for the miner harness. It sequences reset into CHANNELS miner cores and counts run cycles from release. It records which core signals completion first and ends the run on all-done or on a cycle timeout. A status LED shows the outcome. It sits between the board clock/reset and the per-core `led`/done outputs of the `Wrapper` instances, and is synthesisable so the same run sequencing works on hardware and in simulation.

---
 rtl/miner_run_monitor.sv | 175 +++++++++++++++++
 tb/tb_miner_run_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/miner_run_monitor.sv
// Run controller for the miner harness: sequences core reset, counts run
// cycles, tracks per-core completion and the first finisher, ends on all-done
// or timeout, and drives an outcome LED.
//
// Optional build macro: RUN_MONITOR_LATENCY_EN (per-core latency registers).
//
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   start          - begin/restart a run (level)
//   done_in        - per-core done flags
//   core_reset     - reset to all cores (bits identical)
//   busy/all_done/timeout - RSEQ|RUN / DONE / TMO indicators
//   cycle_count    - run cycles elapsed
//   done_mask      - sticky per-core completion
//   winner_valid/winner_idx - first completing core
//   latency        - per-core completion cycle (zero unless macro defined)
//   status_led     - outcome indicator
module miner_run_monitor #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 250,
    parameter int BLINK_W      = 24,
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CHANNELS-1:0]       done_in,
    output logic [CHANNELS-1:0]       core_reset,
    output logic                      busy,
    output logic                      all_done,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CHANNELS-1:0]       done_mask,
    output logic                      winner_valid,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [CHANNELS*CNT_W-1:0] latency,
    output logic                      status_led
);

    typedef enum logic [2:0] {IDLE, RSEQ, RUN, DONE, TMO} state_t;

    localparam logic [31:0]      RSEQ_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [31:0]         rseq_q, rseq_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic                wv_q, wv_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLINK_W-1:0]  div_q;
    logic [IDX_W-1:0]    first_idx;
    logic                clear;

    // Lowest set index of done_in: descending scan, last hit wins.
    always_comb begin
        first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (done_in[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        rseq_d  = rseq_q;
        unique case (state_q)
            IDLE, DONE, TMO: begin
                if (start) begin
                    state_d = RSEQ;
                    rseq_d  = '0;
                end
            end
            RSEQ: begin
                if (rseq_q == RSEQ_LAST) state_d = RUN;
                else                     rseq_d  = rseq_q + 32'd1;
            end
            RUN: begin
                if (&(mask_q | done_in))  state_d = DONE;
                else if (cnt_q == TMO_LAST) state_d = TMO;
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are cleared on entry to RSEQ so they read zero from its first cycle.
    assign clear = (state_q == RSEQ) || (state_d == RSEQ);

    always_comb begin
        cnt_d  = cnt_q;
        mask_d = mask_q;
        wv_d   = wv_q;
        idx_d  = idx_q;
        if (clear) begin
            cnt_d  = '0;
            mask_d = '0;
            wv_d   = 1'b0;
            idx_d  = '0;
        end else if (state_q == RUN) begin
            mask_d = mask_q | done_in;
            if (!wv_q && (|done_in)) begin
                wv_d  = 1'b1;
                idx_d = first_idx;
            end
            // The count freezes on the deciding cycle of the run.
            if (state_d == RUN && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rseq_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            wv_q    <= 1'b0;
            idx_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            rseq_q  <= rseq_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            wv_q    <= wv_d;
            idx_q   <= idx_d;
            div_q   <= div_q + 1'b1;
        end
    end

`ifdef RUN_MONITOR_LATENCY_EN
    logic [CHANNELS*CNT_W-1:0] lat_q, lat_d;

    // A slice is written only while its mask bit is clear: once per run.
    always_comb begin
        lat_d = lat_q;
        if (clear) begin
            lat_d = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (done_in[i] && !mask_q[i]) lat_d[i*CNT_W +: CNT_W] = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) lat_q <= '0;
        else       lat_q <= lat_d;
    end

    assign latency = lat_q;
`else
    assign latency = '0;
`endif

    always_comb begin
        status_led = 1'b0;
        unique case (state_q)
            RSEQ, RUN: status_led = div_q[BLINK_W-1];
            DONE:      status_led = 1'b1;
            TMO:       status_led = div_q[BLINK_W-3];
            default:   status_led = 1'b0;
        endcase
    end

    assign core_reset   = {CHANNELS{(state_q == IDLE) || (state_q == RSEQ)}};
    assign busy         = (state_q == RSEQ) || (state_q == RUN);
    assign all_done     = (state_q == DONE);
    assign timeout      = (state_q == TMO);
    assign cycle_count  = cnt_q;
    assign done_mask    = mask_q;
    assign winner_valid = wv_q;
    assign winner_idx   = idx_q;

endmodule

// File: tb/tb_miner_run_monitor.sv
// Directed bench for miner_run_monitor: vector table for the main run and
// restart, hand sequences for timeout, late done, reset mid-run and LED.
module tb_miner_run_monitor;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   done_in;
    logic [3:0]   core_reset;
    logic         busy, all_done, timeout;
    logic [31:0]  cycle_count;
    logic [3:0]   done_mask;
    logic         winner_valid;
    logic [1:0]   winner_idx;
    logic [127:0] latency;
    logic         status_led;

    always #5 clk = ~clk;

    miner_run_monitor #(
        .CHANNELS(4), .CNT_W(32), .RESET_CYCLES(4),
        .TIMEOUT(250), .BLINK_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .done_in(done_in),
        .core_reset(core_reset), .busy(busy), .all_done(all_done),
        .timeout(timeout), .cycle_count(cycle_count),
        .done_mask(done_mask), .winner_valid(winner_valid),
        .winner_idx(winner_idx), .latency(latency),
        .status_led(status_led)
    );

    // Reference blink divider: free-running, zeroed by reset.
    logic [3:0] tdiv;
    always @(posedge clk) begin
        if (reset) tdiv <= 4'd0;
        else       tdiv <= tdiv + 4'd1;
    end

    typedef struct {
        int          n;
        logic        st;
        logic [3:0]  din;
        logic [3:0]  cr;
        logic        busy;
        logic        alld;
        logic        tmo;
        logic [31:0] cnt;
        logic [3:0]  mask;
        logic        wv;
        logic [1:0]  idx;
    } vec_t;

    vec_t v[14];
    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] lat_exp;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start   = v[i].st;
            done_in = v[i].din;
            step(v[i].n);
            chk($sformatf("v%0d.core_reset", i), core_reset, v[i].cr);
            chk($sformatf("v%0d.busy", i), busy, v[i].busy);
            chk($sformatf("v%0d.all_done", i), all_done, v[i].alld);
            chk($sformatf("v%0d.timeout", i), timeout, v[i].tmo);
            chk($sformatf("v%0d.count", i), cycle_count, v[i].cnt);
            chk($sformatf("v%0d.mask", i), done_mask, v[i].mask);
            chk($sformatf("v%0d.wvalid", i), winner_valid, v[i].wv);
            chk($sformatf("v%0d.widx", i), winner_idx, v[i].idx);
        end
    endtask

    initial begin
        //        n  st  din    cr     busy alld tmo  cnt     mask   wv idx
        v[0]  = '{1, 1, 4'h0, 4'hF, 1, 0, 0, 32'd0,  4'h0, 0, 2'd0};
        v[1]  = '{3, 0, 4'h0, 4'hF, 1, 0, 0, 32'd0,  4'h0, 0, 2'd0};
        v[2]  = '{1, 0, 4'h0, 4'h0, 1, 0, 0, 32'd0,  4'h0, 0, 2'd0};
        v[3]  = '{10, 0, 4'h0, 4'h0, 1, 0, 0, 32'd10, 4'h0, 0, 2'd0};
        v[4]  = '{1, 0, 4'h6, 4'h0, 1, 0, 0, 32'd11, 4'h6, 1, 2'd1};
        v[5]  = '{9, 0, 4'h0, 4'h0, 1, 0, 0, 32'd20, 4'h6, 1, 2'd1};
        v[6]  = '{1, 0, 4'h1, 4'h0, 1, 0, 0, 32'd21, 4'h7, 1, 2'd1};
        v[7]  = '{9, 0, 4'h0, 4'h0, 1, 0, 0, 32'd30, 4'h7, 1, 2'd1};
        v[8]  = '{1, 0, 4'h8, 4'h0, 0, 1, 0, 32'd30, 4'hF, 1, 2'd1};
        v[9]  = '{1, 0, 4'h4, 4'h0, 0, 1, 0, 32'd30, 4'hF, 1, 2'd1};
        v[10] = '{3, 0, 4'h0, 4'h0, 0, 1, 0, 32'd30, 4'hF, 1, 2'd1};
        v[11] = '{1, 1, 4'h0, 4'hF, 1, 0, 0, 32'd0,  4'h0, 0, 2'd0};
        v[12] = '{3, 0, 4'hF, 4'hF, 1, 0, 0, 32'd0,  4'h0, 0, 2'd0};
        v[13] = '{1, 0, 4'h0, 4'h0, 1, 0, 0, 32'd0,  4'h0, 0, 2'd0};
`ifdef RUN_MONITOR_LATENCY_EN
        lat_exp = {32'd30, 32'd10, 32'd10, 32'd20};
`else
        lat_exp = '0;
`endif

        reset = 1'b1; start = 1'b0; done_in = 4'h0;
        step(2);
        chk("rst.core_reset", core_reset, 4'hF);
        chk("rst.busy", busy, 1'b0);
        chk("rst.count", cycle_count, 32'd0);
        chk("rst.latency", latency, 128'd0);
        chk("rst.led", status_led, 1'b0);
        reset = 1'b0;
        step(1);
        chk("idle.core_reset", core_reset, 4'hF);

        // Main run and freeze in DONE.
        run_vecs(0, 10);
        chk("done.latency", latency, lat_exp);
        chk("done.led", status_led, 1'b1);

        // Restart from DONE; done_in during RSEQ ignored.
        run_vecs(11, 13);
        chk("restart.latency", latency, 128'd0);
        chk("run.led0", status_led, tdiv[3]);

        // Timeout: core 3 never finishes.
        done_in = 4'h7;
        step(1);
        chk("tmo.mask_early", done_mask, 4'h7);
        chk("tmo.widx", winner_idx, 2'd0);
        done_in = 4'h0;
        step(100);
        chk("run.led1", status_led, tdiv[3]);
        step(148);
        chk("tmo.pre_count", cycle_count, 32'd249);
        chk("tmo.pre_busy", busy, 1'b1);
        step(1);
        chk("tmo.timeout", timeout, 1'b1);
        chk("tmo.busy", busy, 1'b0);
        chk("tmo.all_done", all_done, 1'b0);
        chk("tmo.count", cycle_count, 32'd249);
        chk("tmo.mask", done_mask, 4'h7);
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("tmo.led%0d", k), status_led, tdiv[1]);
        end
        chk("tmo.count_frozen", cycle_count, 32'd249);

        // Last core at count 249: DONE wins over timeout.
        start = 1'b1;
        step(1);
        chk("late.rseq_cr", core_reset, 4'hF);
        start = 1'b0;
        step(4);
        chk("late.run_count", cycle_count, 32'd0);
        done_in = 4'h7;
        step(1);
        done_in = 4'h0;
        step(248);
        chk("late.pre_count", cycle_count, 32'd249);
        done_in = 4'h8;
        step(1);
        done_in = 4'h0;
        chk("late.all_done", all_done, 1'b1);
        chk("late.timeout", timeout, 1'b0);
        chk("late.count", cycle_count, 32'd249);
        chk("late.mask", done_mask, 4'hF);

        // Reset mid-run at count 50.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        done_in = 4'h1;
        step(1);
        done_in = 4'h0;
        step(49);
        chk("mid.count", cycle_count, 32'd50);
        chk("mid.mask", done_mask, 4'h1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid.core_reset", core_reset, 4'hF);
        chk("mid.busy", busy, 1'b0);
        chk("mid.count", cycle_count, 32'd0);
        chk("mid.mask", done_mask, 4'h0);
        chk("mid.wvalid", winner_valid, 1'b0);
        chk("mid.led", status_led, 1'b0);
        chk("mid.latency", latency, 128'd0);
        start = 1'b1;
        step(1);
        chk("mid.rseq_busy", busy, 1'b1);
        start = 1'b0;
        step(4);
        chk("mid.run_cr", core_reset, 4'h0);
        chk("mid.run_count0", cycle_count, 32'd0);
        step(5);
        chk("mid.run_count5", cycle_count, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
